// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces one raw board button and turns
// each accepted press (and each hold-to-repeat tick) into a single-cycle
// press_pulse, used as the count enable of the downstream display counter.
module key_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] HOLD_CYCLES     = 24'd25000000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000,
  parameter logic        REPEAT_EN       = 1'b1,
  parameter logic        BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse,
  output logic btn_level,
  output logic held
);

  // Counter widths hold exactly their terminal value; all counters saturate.
  localparam int DW = $clog2(32'(DEBOUNCE_CYCLES) + 1);
  localparam int HW = $clog2(32'(HOLD_CYCLES) + 1);
  localparam int RW = $clog2(32'(REPEAT_CYCLES) + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LST = HW'(HOLD_CYCLES - 24'd1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LST  = RW'(REPEAT_CYCLES - 24'd1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DEB,
    PRESSED,
    REPEAT,
    RELEASE_DEB
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] deb_cnt, deb_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic          pulse_nxt, level_nxt, held_nxt;

  logic [1:0]    sync_pipe;
  logic          s;

  // Two-flop synchroniser; polarity is normalised so 1 always means pressed.
  always_ff @(posedge clk) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], btn_raw ^ BTN_ACTIVE_LOW};
  end

  assign s = sync_pipe[1];

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      press_pulse <= 1'b0;
      btn_level   <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      hold_cnt    <= hold_nxt;
      rep_cnt     <= rep_nxt;
      press_pulse <= pulse_nxt;
      btn_level   <= level_nxt;
      held        <= held_nxt;
    end
  end

  // Next-state logic. A released sample (s=0) is tested first in PRESSED and
  // REPEAT so a release always beats a coincident hold/repeat terminal count.
  // Hold and repeat counts are left untouched in RELEASE_DEB so a release
  // glitch resumes the cadence where it left off; held tells us which state
  // to go back to.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    rep_nxt   = rep_cnt;
    pulse_nxt = 1'b0;
    level_nxt = btn_level;
    held_nxt  = held;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_DEB;
          deb_nxt   = DEB_ONE;
        end
      end
      PRESS_DEB: begin
        if (!s) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt = PRESSED;
          deb_nxt   = '0;
          hold_nxt  = '0;
          pulse_nxt = 1'b1;
          level_nxt = 1'b1;
        end else begin
          deb_nxt = deb_cnt + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_DEB;
          deb_nxt   = DEB_ONE;
        end else if (REPEAT_EN && (hold_cnt == HOLD_LST)) begin
          state_nxt = REPEAT;
          rep_nxt   = '0;
          pulse_nxt = 1'b1;
          held_nxt  = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      REPEAT: begin
        if (!s) begin
          state_nxt = RELEASE_DEB;
          deb_nxt   = DEB_ONE;
        end else if (rep_cnt == REP_LST) begin
          rep_nxt   = '0;
          pulse_nxt = 1'b1;
        end else if (rep_cnt != REP_MAX) begin
          rep_nxt = rep_cnt + RW'(1);
        end
      end
      RELEASE_DEB: begin
        if (s) begin
          state_nxt = held ? REPEAT : PRESSED;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
          level_nxt = 1'b0;
          held_nxt  = 1'b0;
        end else begin
          deb_nxt = deb_cnt + DEB_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic btn_n;

  logic p0, l0, h0;
  logic p1, l1, h1;
  logic p2, l2, h2;

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  key_conditioner #(
    .DEBOUNCE_CYCLES(16'd4), .HOLD_CYCLES(24'd10), .REPEAT_CYCLES(24'd3),
    .REPEAT_EN(1'b0), .BTN_ACTIVE_LOW(1'b0)
  ) dut_norep (
    .clk(clk), .reset(reset), .btn_raw(btn),
    .press_pulse(p0), .btn_level(l0), .held(h0)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(16'd4), .HOLD_CYCLES(24'd10), .REPEAT_CYCLES(24'd3),
    .REPEAT_EN(1'b1), .BTN_ACTIVE_LOW(1'b0)
  ) dut_rep (
    .clk(clk), .reset(reset), .btn_raw(btn),
    .press_pulse(p1), .btn_level(l1), .held(h1)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(16'd4), .HOLD_CYCLES(24'd10), .REPEAT_CYCLES(24'd3),
    .REPEAT_EN(1'b0), .BTN_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .reset(reset), .btn_raw(btn_n),
    .press_pulse(p2), .btn_level(l2), .held(h2)
  );

  typedef struct {
    int         sel;
    logic       rst_n;
    logic       b;
    logic [2:0] exp;
    int         tid;
    int         idx;
  } vec_t;

  vec_t  vecs[$];
  string tname[8];
  int    cur_tid;
  int    cur_idx;
  int    n_vec;
  int    n_err;

  task automatic add(input int sel, input logic rn, input logic b,
                     input logic p, input logic l, input logic h);
    vec_t v;
    v.sel   = sel;
    v.rst_n = rn;
    v.b     = b;
    v.exp   = {p, l, h};
    v.tid   = cur_tid;
    v.idx   = cur_idx;
    vecs.push_back(v);
    cur_idx++;
  endtask

  task automatic begin_test(input int tid, input int sel);
    cur_tid = tid;
    cur_idx = -1;
    add(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] got;
    logic [8:0] all_out;
    int         seen_at;
    tname[0] = "clean_press";
    tname[1] = "bounce";
    tname[2] = "auto_repeat";
    tname[3] = "release_glitch";
    tname[4] = "release_beats_hold";
    tname[5] = "repeat_resume";
    tname[6] = "reset_mid_repeat";
    tname[7] = "active_low";
    n_vec = 0;
    n_err = 0;

    begin_test(0, 0);
    for (int i = 0; i < 20; i++) add(0, 1, 1, i == 6, i >= 6, 0);
    for (int j = 0; j < 8; j++)  add(0, 1, 0, 0, j < 6, 0);

    begin_test(1, 0);
    for (int i = 0; i < 8; i++)  add(0, 1, ((i / 2) % 2) == 0, 0, 0, 0);
    for (int i = 8; i < 18; i++) add(0, 1, 1, i == 14, i >= 14, 0);

    begin_test(2, 1);
    for (int i = 0; i < 38; i++)
      add(1, 1, i < 30,
          i == 6 || i == 16 || i == 19 || i == 22 || i == 25 || i == 28 || i == 31,
          i >= 6 && i < 36, i >= 16 && i < 36);

    begin_test(3, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 1, i == 6, i >= 6, 0);
    for (int i = 0; i < 2; i++)  add(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++)  add(0, 1, 1, 0, 1, 0);
    for (int j = 0; j < 8; j++)  add(0, 1, 0, 0, j < 6, 0);

    begin_test(4, 1);
    for (int i = 0; i < 22; i++) add(1, 1, i < 14, i == 6, i >= 6 && i < 20, 0);

    begin_test(5, 1);
    for (int i = 0; i < 42; i++)
      add(1, 1, i < 34 && !(i == 22 || i == 23),
          i == 6 || i == 16 || i == 19 || i == 22 || i == 28 || i == 31 || i == 34,
          i >= 6 && i < 40, i >= 16 && i < 40);

    begin_test(6, 1);
    for (int i = 0; i < 31; i++)
      add(1, i != 20, 1, i == 6 || i == 16 || i == 19 || i == 27,
          (i >= 6 && i < 20) || i >= 27, i >= 16 && i < 20);

    begin_test(7, 2);
    for (int i = 0; i < 12; i++) add(2, 1, 1, i == 6, i >= 6, 0);
    for (int j = 0; j < 8; j++)  add(2, 1, 0, 0, j < 6, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset = vecs[k].rst_n;
      btn   = vecs[k].b;
      @(posedge clk);
      #1;
      case (vecs[k].sel)
        0:       got = {p0, l0, h0};
        1:       got = {p1, l1, h1};
        default: got = {p2, l2, h2};
      endcase
      n_vec++;
      if (got !== vecs[k].exp) begin
        n_err++;
        $display("FAIL %s step %0d: pulse/level/held got %b want %b",
                 tname[vecs[k].tid], vecs[k].idx, got, vecs[k].exp);
      end
    end

    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      reset = 1'b0;
      btn   = 1'b1;
      @(posedge clk);
      #1;
      all_out = {p0, l0, h0, p1, l1, h1, p2, l2, h2};
      n_vec++;
      if (all_out !== 9'b0) begin
        n_err++;
        $display("FAIL reset_state edge %0d: outputs %b want all zero", r, all_out);
      end
    end

    seen_at = -1;
    @(negedge clk);
    reset = 1'b1;
    btn   = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (p0 === 1'b1 && seen_at < 0) seen_at = t;
      if (t < 19) @(negedge clk);
    end
    n_vec++;
    if (seen_at < 0) begin
      n_err++;
      $display("FAIL wait_press: timeout, no press_pulse within 20 edges");
    end else if (seen_at != 6) begin
      n_err++;
      $display("FAIL wait_press: press_pulse after edge %0d want 6", seen_at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule
